// File: rtl/timer.sv
// 8-bit timer/counter: clk or synchronized ext_clk source, power-of-two prescaler,
// two compare channels (level or toggle), byte-wide register interface.
module timer (
    input  logic       clk,
    input  logic       ext_clk,
    input  logic       enable,
    input  logic       rst,
    input  logic [2:0] config_address,
    input  logic       config_write_enable,
    input  logic [7:0] write_data,
    output logic [7:0] read_data,
    output logic       comparator_1_output,
    output logic       comparator_0_output
);
    localparam logic [2:0] ADDR_CTRL   = 3'd0;
    localparam logic [2:0] ADDR_COUNT  = 3'd1;
    localparam logic [2:0] ADDR_STATUS = 3'd4;

    logic [7:0] r_ctrl;
    logic [7:0] r_count;
    logic [7:0] r_presc;
    logic [2:0] r_status;
    logic [1:0] r_sync;
    logic       r_ext_prev;

    logic       w_wr_ctrl;
    logic       w_wr_count;
    logic       w_wr_status;
    logic       w_advance;
    logic       w_event;
    logic       w_tick;
    logic       w_tick_eff;
    logic       w_ctc_clear;
    logic       w_ovf;
    logic [7:0] w_ps_max;
    logic [7:0] w_tick_value;
    logic [7:0] w_count_next;
    logic [7:0] w_presc_next;
    logic [2:0] w_status_clr;
    logic [2:0] w_status_next;
    logic [1:0] w_match;
    logic [1:0] w_out;
    logic [1:0][7:0] w_cmp;

    assign w_wr_ctrl   = config_write_enable && (config_address == ADDR_CTRL);
    assign w_wr_count  = config_write_enable && (config_address == ADDR_COUNT);
    assign w_wr_status = config_write_enable && (config_address == ADDR_STATUS);

    // ext_clk event fires one cycle after the synchronized level first reads high
    assign w_event   = r_ctrl[1] ? (r_sync[1] & ~r_ext_prev) : 1'b1;
    assign w_advance = r_ctrl[0] & enable & w_event;
    assign w_ps_max  = ~(8'hFF << r_ctrl[4:2]);
    assign w_tick    = w_advance & (r_presc == w_ps_max);
    assign w_tick_eff = w_tick & ~w_wr_count;

    assign w_ctc_clear  = r_ctrl[5] & (r_count == w_cmp[0]);
    assign w_tick_value = w_ctc_clear ? 8'd0 : r_count + 8'd1;
    assign w_ovf        = w_tick_eff & ~w_ctc_clear & (r_count == 8'hFF);

    always_comb begin
        w_count_next = r_count;
        if (w_wr_count)
            w_count_next = write_data;
        else if (w_tick)
            w_count_next = w_tick_value;
    end

    always_comb begin
        w_presc_next = r_presc;
        if (w_wr_ctrl || w_wr_count || !r_ctrl[0])
            w_presc_next = 8'd0;
        else if (w_advance)
            w_presc_next = w_tick ? 8'd0 : r_presc + 8'd1;
    end

    // a set in the same cycle as a write-1-clear wins
    assign w_status_clr  = w_wr_status ? write_data[2:0] : 3'b000;
    assign w_status_next = (r_status & ~w_status_clr) | {w_ovf, w_match};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ctrl     <= 8'd0;
            r_count    <= 8'd0;
            r_presc    <= 8'd0;
            r_status   <= 3'd0;
            r_sync     <= 2'b00;
            r_ext_prev <= 1'b0;
        end else begin
            if (w_wr_ctrl)
                r_ctrl <= write_data;
            r_count    <= w_count_next;
            r_presc    <= w_presc_next;
            r_status   <= w_status_next;
            r_sync     <= {r_sync[0], ext_clk};
            r_ext_prev <= r_sync[1];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_chan
            logic [7:0] r_cmp;
            logic       r_out;
            logic       w_wr_cmp;
            logic [7:0] w_cmp_next;

            assign w_wr_cmp    = config_write_enable && (config_address == 3'(2 + gi));
            assign w_cmp_next  = w_wr_cmp ? write_data : r_cmp;
            assign w_match[gi] = w_tick_eff & (w_tick_value == r_cmp);
            assign w_cmp[gi]   = r_cmp;
            assign w_out[gi]   = r_out;

            // level mode registers the equality of the post-edge count and compare values
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_cmp <= 8'd0;
                    r_out <= 1'b0;
                end else begin
                    r_cmp <= w_cmp_next;
                    if (r_ctrl[6 + gi])
                        r_out <= r_out ^ w_match[gi];
                    else
                        r_out <= (w_count_next == w_cmp_next);
                end
            end
        end
    endgenerate

    assign comparator_0_output = w_out[0];
    assign comparator_1_output = w_out[1];

    always_comb begin
        read_data = 8'd0;
        case (config_address)
            3'd0:    read_data = r_ctrl;
            3'd1:    read_data = r_count;
            3'd2:    read_data = w_cmp[0];
            3'd3:    read_data = w_cmp[1];
            3'd4:    read_data = {5'd0, r_status};
            default: read_data = 8'd0;
        endcase
    end
endmodule

// File: tb/tb_timer.sv
// Randomized scoreboard bench for timer: a cycle-level reference model predicts
// the register read-back and both comparator outputs after every clk edge.
module tb_timer;
    logic       clk = 1'b0;
    logic       ext_clk = 1'b0;
    logic       enable = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] config_address = 3'd0;
    logic       config_write_enable = 1'b0;
    logic [7:0] write_data = 8'd0;
    logic [7:0] read_data;
    logic       comparator_1_output;
    logic       comparator_0_output;

    timer dut (
        .clk                 (clk),
        .ext_clk             (ext_clk),
        .enable              (enable),
        .rst                 (rst),
        .config_address      (config_address),
        .config_write_enable (config_write_enable),
        .write_data          (write_data),
        .read_data           (read_data),
        .comparator_1_output (comparator_1_output),
        .comparator_0_output (comparator_0_output)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         addr;
        logic [7:0] rd;
        logic       o0;
        logic       o1;
    } exp_t;
    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    int m_ctrl, m_count, m_status, m_events, m_ext_last;
    int m_cmp[2];
    int m_out[2];
    int m_dq[2];

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic void model_reset();
        m_ctrl = 0; m_count = 0; m_status = 0; m_events = 0; m_ext_last = 0;
        m_cmp[0] = 0; m_cmp[1] = 0; m_out[0] = 0; m_out[1] = 0;
        m_dq[0] = 0; m_dq[1] = 0;
    endfunction

    function automatic logic [7:0] model_read(input int a);
        case (a)
            0: return 8'(m_ctrl);
            1: return 8'(m_count);
            2: return 8'(m_cmp[0]);
            3: return 8'(m_cmp[1]);
            4: return 8'(m_status);
            default: return 8'd0;
        endcase
    endfunction

    // One clk edge: an ext_clk rise sampled now is counted two edges later.
    function automatic void model_edge(input bit we, input int a, input int d, input bit en, input bit ext);
        bit ext_evt, src_evt, tick, ovf, clear;
        bit match[2];
        int period, nxt;
        ext_evt = (m_dq[0] != 0);
        m_dq[0] = m_dq[1];
        m_dq[1] = (ext && m_ext_last == 0) ? 1 : 0;
        m_ext_last = ext;
        src_evt = m_ctrl[1] ? ext_evt : 1'b1;
        period = 1 << ((m_ctrl >> 2) & 7);
        tick = 0; ovf = 0; match[0] = 0; match[1] = 0;
        if (m_ctrl[0] && en && src_evt) begin
            m_events++;
            if (m_events == period) begin
                tick = 1;
                m_events = 0;
            end
        end
        if (!m_ctrl[0] || (we && (a == 0 || a == 1)))
            m_events = 0;
        if (we && a == 1) begin
            m_count = d;
        end else if (tick) begin
            clear = m_ctrl[5] && (m_count == m_cmp[0]);
            nxt = clear ? 0 : (m_count + 1) % 256;
            ovf = !clear && m_count == 255;
            for (int n = 0; n < 2; n++) match[n] = (nxt == m_cmp[n]);
            m_count = nxt;
        end
        for (int n = 0; n < 2; n++)
            if (m_ctrl[6 + n] && match[n]) m_out[n] = 1 - m_out[n];
        if (we && a == 4) m_status = m_status & ~(d & 7);
        m_status = m_status | (match[0] ? 1 : 0) | (match[1] ? 2 : 0) | (ovf ? 4 : 0);
        if (we && (a == 2 || a == 3)) m_cmp[a - 2] = d;
        for (int n = 0; n < 2; n++)
            if (!m_ctrl[6 + n]) m_out[n] = (m_count == m_cmp[n]) ? 1 : 0;
        if (we && a == 0) m_ctrl = d;
    endfunction

    task automatic step(input bit we, input int a, input int d, input bit en, input bit ext);
        exp_t e;
        @(negedge clk);
        config_write_enable = we;
        config_address      = 3'(a);
        write_data          = 8'(d);
        enable              = en;
        ext_clk             = ext;
        model_edge(we, a, d, en, ext);
        e.addr = a;
        e.rd   = model_read(a);
        e.o0   = m_out[0][0];
        e.o1   = m_out[1][0];
        exp_q.push_back(e);
    endtask

    // monitor: compare the DUT after each edge against the queued prediction
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check($sformatf("read_data[a%0d]", e.addr), int'(read_data), int'(e.rd));
                check("comparator_0_output", int'(comparator_0_output), int'(e.o0));
                check("comparator_1_output", int'(comparator_1_output), int'(e.o1));
            end
        end
    end

    initial begin
        int hold;
        bit ext_v, we;
        int a, d;
        model_reset();
        #12;
        check("reset comparator_0_output", int'(comparator_0_output), 0);
        check("reset comparator_1_output", int'(comparator_1_output), 0);
        check("reset read_data", int'(read_data), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) step(0, i, 0, 1, 0);

        // free-running count with CMP0=3, then clear M0
        step(1, 2, 3, 1, 0);
        step(1, 0, 8'h01, 1, 0);
        for (int i = 0; i < 6; i++) step(0, 1, 0, 1, 0);
        step(0, 4, 0, 1, 0);
        step(1, 4, 1, 1, 0);
        step(0, 4, 0, 1, 0);

        // clear-on-match with toggle output
        step(1, 2, 4, 1, 0);
        step(1, 1, 0, 1, 0);
        step(1, 0, 8'h61, 1, 0);
        for (int i = 0; i < 14; i++) step(0, 1, 0, 1, 0);
        step(0, 4, 0, 1, 0);

        // prescale by 4 through the 0xFF wrap
        step(1, 4, 7, 1, 0);
        step(1, 0, 8'h09, 1, 0);
        step(1, 1, 8'hFE, 1, 0);
        for (int i = 0; i < 12; i++) step(0, 1, 0, 1, 0);
        step(0, 4, 0, 1, 0);

        // external source: 5 pulses counted, then 5 pulses with enable low
        step(1, 1, 0, 1, 0);
        step(1, 0, 8'h03, 1, 0);
        for (int p = 0; p < 10; p++) begin
            step(0, 1, 0, p < 5, 1);
            step(0, 1, 0, p < 5, 1);
            step(0, 1, 0, p < 5, 0);
            step(0, 1, 0, p < 5, 0);
        end

        // level output after a COUNT load with RUN low
        step(1, 0, 0, 1, 0);
        step(1, 3, 8'h10, 1, 0);
        step(1, 1, 8'h10, 1, 0);
        step(0, 3, 0, 1, 0);
        step(0, 4, 0, 1, 0);

        // randomized traffic
        hold = 0; ext_v = 0;
        for (int i = 0; i < 3000; i++) begin
            hold++;
            if (hold >= 2 && $urandom_range(1, 0) == 1) begin
                ext_v = ~ext_v;
                hold = 0;
            end
            we = ($urandom_range(5, 0) == 0);
            a  = $urandom_range(7, 0);
            d  = $urandom_range(255, 0);
            if (we && a == 0 && $urandom_range(3, 0) != 0) d = d & 8'hEF;
            step(we, a, d, $urandom_range(7, 0) != 0, ext_v);
        end

        // asynchronous reset with a live count and a high level output
        step(1, 0, 8'h01, 1, 0);
        step(1, 3, 8'h30, 1, 0);
        step(1, 1, 8'h30, 1, 0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        config_write_enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            config_address = 3'(i);
            #1;
            check($sformatf("async reset read a%0d", i), int'(read_data), 0);
        end
        check("async reset comparator_0_output", int'(comparator_0_output), 0);
        check("async reset comparator_1_output", int'(comparator_1_output), 0);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 5; i++) step(0, i, 0, 1, 0);
        step(1, 0, 8'h01, 1, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 1, 0);

        repeat (3) @(posedge clk);
        #4;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/timer.md
Name: timer

Overview:
- 8-bit general-purpose timer/counter with two compare channels and a byte-wide configuration/status register interface.
- Counts either system clock cycles or rising edges of an external clock input, through a power-of-two prescaler.
- Drives two comparator outputs used by the surrounding design as match/PWM-style signals.

Parameters:
- none; all widths are fixed: 8-bit data, 3-bit address.

Ports:
- clk  in  1  system clock; all logic is on its rising edge
- ext_clk  in  1  external count source, asynchronous to clk; must be slower than clk/2
- enable  in  1  global enable; low freezes prescaler and counter; register writes still accepted
- rst  in  1  asynchronous, active-high reset
- config_address  in  3  register address
- config_write_enable  in  1  writes write_data to config_address on the clk edge
- write_data  in  8  write data
- read_data  out  8  combinational read of the register at config_address
- comparator_1_output  out  1  channel 1 output
- comparator_0_output  out  1  channel 0 output

Behaviour:
- Register map:
  - 0 CTRL (rw): [0] RUN; [1] SRC (0 = clk, 1 = ext_clk rising edges); [4:2] PS, divide by 2^PS; [5] CTC, clear counter on CMP0 match; [6] T0 (comparator_0 toggle mode); [7] T1 (comparator_1 toggle mode).
  - 1 COUNT (rw): a write loads the counter.
  - 2 CMP0 (rw).
  - 3 CMP1 (rw).
  - 4 STATUS: [0] M0, [1] M1, [2] OVF; [7:3] read 0; writing 1 to a bit clears it.
  - 5-7: read 0x00; writes ignored.
- Reset: all registers, counter, prescaler and sync flops go to 0; both outputs 0; read_data reflects the zeroed registers.
- Source event:
  - SRC=0: every clk cycle.
  - SRC=1: ext_clk passes a 2-flop synchronizer plus an edge-detect flop; one event per ext_clk rising edge, 3-4 clk cycles latency.
- Prescaler:
  - 8-bit count, advances on source events only when RUN and enable are both high.
  - Produces a tick when it equals 2^PS-1, then returns to 0. PS=0 gives a tick on every event.
  - Held at 0 while RUN=0.
  - Cleared on any write to CTRL or COUNT.
- Counter update on a tick:
  - If CTC=1 and count==CMP0: next = 0.
  - Else next = count+1, wrapping 255 to 0. The wrap sets OVF; a CTC clear does not.
- A COUNT write takes precedence over a tick in the same cycle and is not a match event.
- Match event n: a tick whose next counter value equals CMPn. It sets Mn. In toggle mode it also inverts comparator_n_output.
- Level mode (Tn=0): comparator_n_output is registered and high exactly in the cycles where the counter register equals CMPn, regardless of RUN. This includes after a COUNT or CMP write.
- Switching Tn changes the output source on the next clk edge. Toggle state starts from the current output value.
- Simultaneous status set and write-1-clear on the same bit: the set wins.
- enable low: counter, prescaler and toggle state hold; level-mode outputs still follow the compare.
- Read is combinational, with no wait states. Writes take effect on the clk edge.
- rst asserted mid-count returns everything to the reset state immediately.

Test Plan:
- Reset, then read addresses 0-7 -> all 0x00; both outputs 0.
- CMP0=3, CTRL=0x01 (RUN, clk, PS=0) -> count 1,2,3,4... one per clk; comparator_0_output high only in the cycle count==3; STATUS=0x01 after; write 0x01 to STATUS -> 0x00.
- CTRL=0x21 (CTC), CMP0=4, CTRL bit6 set -> count sequence 0..4,0..4; comparator_0_output toggles every 5 clks; OVF never set.
- CTRL=0x09 (PS=2) -> count advances once per 4 clks; write COUNT=0xFE -> reaches 0xFF then 0x00; STATUS OVF=1.
- CTRL=0x03 (SRC=ext), 5 ext_clk pulses of 4 clk period -> COUNT=5 within 4 clks of the last edge; enable=0 during pulses -> count frozen.
- CMP1=0x10, write COUNT=0x10 with RUN=0 -> comparator_1_output high next cycle; M1 stays 0; rst mid-run -> outputs and registers 0 asynchronously.
